// File: rtl/papyrus_pkg.sv
// Shared types and board defaults for the push-button input path.
// Debounce FSM state encoding plus clk50-based timing constants.
package papyrus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PDB,
        HELD,
        RDB
    } btn_state_t;

    localparam int unsigned CLK_HZ      = 50000000;
    localparam int unsigned DEBOUNCE_MS = 10;
    localparam int unsigned LONG_MS     = 1000;

    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for an asynchronous pin.
// Reset value is a parameter so idle pins come out of reset at rest.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two-stage capture to resolve metastability
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= RST_VAL;
            s2_q <= RST_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_reader.sv
// Debounced push-button reader with press/release strobes
// and short/long press classification by hold duration.
module button_reader
    import papyrus_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
    parameter int unsigned LONG_CYCLES     = ms_to_cycles(LONG_MS),
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned HOLD_W          = 32
) (
    input  logic              clk50,
    input  logic              rst,
    input  logic              btn_raw,
    output logic              pressed,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              short_press,
    output logic              long_press,
    output logic [HOLD_W-1:0] held_cycles
);

    localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ?
                                 $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0]     DMAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONGV = HOLD_W'(LONG_CYCLES);

    logic btn_s;
    logic p_s;

    sync2 #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk_i (clk50),
        .rst_i (rst),
        .d_i   (btn_raw),
        .q_o   (btn_s)
    );

    assign p_s = btn_s ^ ACTIVE_LOW;

    btn_state_t        state_q, state_d;
    logic [DW-1:0]     dcnt_q, dcnt_d;
    logic [HOLD_W-1:0] held_q, held_d;
    logic [HOLD_W-1:0] held_inc;
    logic              long_seen_q, long_seen_d;
    logic              pressed_q, pressed_d;
    logic              ppul_q, ppul_d;
    logic              rpul_q, rpul_d;
    logic              short_q, short_d;
    logic              long_q, long_d;

    assign held_inc = (&held_q) ? held_q : held_q + HOLD_W'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        held_d      = held_q;
        long_seen_d = long_seen_q;
        pressed_d   = pressed_q;
        ppul_d      = 1'b0;
        rpul_d      = 1'b0;
        short_d     = 1'b0;
        long_d      = 1'b0;

        if (state_q == HELD || state_q == RDB) begin
            held_d = held_inc;
            if (held_inc == LONGV && !long_seen_q) begin
                long_d      = 1'b1;
                long_seen_d = 1'b1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (p_s) begin
                    state_d = PDB;
                    dcnt_d  = '0;
                end
            end
            PDB: begin
                if (!p_s) begin
                    state_d = IDLE;
                end else if (dcnt_q == DMAX) begin
                    state_d     = HELD;
                    pressed_d   = 1'b1;
                    ppul_d      = 1'b1;
                    held_d      = '0;
                    long_seen_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            HELD: begin
                if (!p_s) begin
                    state_d = RDB;
                    dcnt_d  = '0;
                end
            end
            RDB: begin
                if (p_s) begin
                    state_d = HELD;
                end else if (dcnt_q == DMAX) begin
                    state_d   = IDLE;
                    pressed_d = 1'b0;
                    rpul_d    = 1'b1;
                    short_d   = !long_seen_d;
                end else begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately on reset
    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            held_q      <= '0;
            long_seen_q <= 1'b0;
            pressed_q   <= 1'b0;
            ppul_q      <= 1'b0;
            rpul_q      <= 1'b0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            held_q      <= held_d;
            long_seen_q <= long_seen_d;
            pressed_q   <= pressed_d;
            ppul_q      <= ppul_d;
            rpul_q      <= rpul_d;
            short_q     <= short_d;
            long_q      <= long_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = ppul_q;
    assign release_pulse = rpul_q;
    assign short_press   = short_q;
    assign long_press    = long_q;
    assign held_cycles   = held_q;

endmodule

// File: tb/tb_button_reader.sv
// Scoreboard bench for button_reader with DEBOUNCE=4, LONG=20.
// Stimulus queues expected strobes; a monitor pops on any strobe.
module tb_button_reader;

    logic        clk50 = 1'b0;
    logic        rst = 1'b1;
    logic        btn_raw = 1'b1;
    logic        pressed;
    logic        press_pulse;
    logic        release_pulse;
    logic        short_press;
    logic        long_press;
    logic [31:0] held_cycles;

    button_reader #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .ACTIVE_LOW      (1'b1),
        .HOLD_W          (32)
    ) dut (
        .clk50         (clk50),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_press   (short_press),
        .long_press    (long_press),
        .held_cycles   (held_cycles)
    );

    always #5 clk50 = ~clk50;

    int cyc = 0;
    always @(posedge clk50) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int       cyc;
        logic [3:0] p;
        bit       chk_held;
        int       held;
    } ev_t;

    ev_t q[$];

    localparam logic [3:0] EV_PRESS = 4'b1000;
    localparam logic [3:0] EV_SHORT = 4'b0110;
    localparam logic [3:0] EV_REL   = 4'b0100;
    localparam logic [3:0] EV_LONG  = 4'b0001;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void push(input int c, input logic [3:0] p,
                                 input bit ch, input int h);
        ev_t e;
        e.cyc = c;
        e.p = p;
        e.chk_held = ch;
        e.held = h;
        q.push_back(e);
    endfunction

    function automatic logic [36:0] outs();
        return {pressed, press_pulse, release_pulse, short_press,
                long_press, held_cycles};
    endfunction

    // Monitor: every strobe must match the oldest expected event
    always @(negedge clk50) begin
        logic [3:0] p;
        ev_t e;
        p = {press_pulse, release_pulse, short_press, long_press};
        if (!rst && p != 4'b0000) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_strobe: got %b at cycle %0d expected none",
                         p, cyc);
            end else begin
                e = q.pop_front();
                chk("strobe_kind", 64'(p), 64'(e.p));
                chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
                if (e.chk_held)
                    chk("strobe_held", 64'(held_cycles), 64'(e.held));
            end
        end
    end

    initial begin
        int base;

        // Reset with pin released
        rst = 1'b1;
        btn_raw = 1'b1;
        repeat (3) @(negedge clk50);
        chk("reset_outs", 64'(outs()), 64'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk50);
        chk("idle_outs", 64'(outs()), 64'd0);

        // Clean short press
        base = cyc + 1;
        btn_raw = 1'b0;
        push(base + 6, EV_PRESS, 1'b1, 0);
        repeat (12) @(negedge clk50);
        chk("short_pressed_lvl", 64'(pressed), 64'd1);
        btn_raw = 1'b1;
        push(base + 18, EV_SHORT, 1'b0, 0);
        repeat (10) @(negedge clk50);
        chk("short_released_lvl", 64'(pressed), 64'd0);

        // Bounce rejection
        repeat (5) begin
            btn_raw = 1'b0;
            repeat (2) @(negedge clk50);
            btn_raw = 1'b1;
            @(negedge clk50);
        end
        repeat (10) @(negedge clk50);
        chk("bounce_pressed_lvl", 64'(pressed), 64'd0);

        // Long press
        base = cyc + 1;
        btn_raw = 1'b0;
        push(base + 6, EV_PRESS, 1'b1, 0);
        push(base + 26, EV_LONG, 1'b1, 20);
        repeat (40) @(negedge clk50);
        chk("long_pressed_lvl", 64'(pressed), 64'd1);
        btn_raw = 1'b1;
        push(base + 46, EV_REL, 1'b0, 0);
        repeat (10) @(negedge clk50);
        chk("long_released_lvl", 64'(pressed), 64'd0);

        // Release bounce during hold
        base = cyc + 1;
        btn_raw = 1'b0;
        push(base + 6, EV_PRESS, 1'b1, 0);
        repeat (10) @(negedge clk50);
        btn_raw = 1'b1;
        repeat (2) @(negedge clk50);
        btn_raw = 1'b0;
        repeat (5) @(negedge clk50);
        chk("relbounce_held", 64'(held_cycles), 64'd10);
        chk("relbounce_pressed", 64'(pressed), 64'd1);
        push(base + 26, EV_LONG, 1'b1, 20);
        repeat (14) @(negedge clk50);
        btn_raw = 1'b1;
        push(base + 37, EV_REL, 1'b0, 0);
        repeat (10) @(negedge clk50);

        // Reset mid-hold, pin kept pressed through reset
        base = cyc + 1;
        btn_raw = 1'b0;
        push(base + 6, EV_PRESS, 1'b1, 0);
        repeat (8) @(negedge clk50);
        chk("midhold_pressed", 64'(pressed), 64'd1);
        rst = 1'b1;
        #1;
        chk("midhold_reset_outs", 64'(outs()), 64'd0);
        repeat (2) @(negedge clk50);
        rst = 1'b0;
        base = cyc + 1;
        push(base + 6, EV_PRESS, 1'b1, 0);
        repeat (10) @(negedge clk50);
        btn_raw = 1'b1;
        push(base + 16, EV_SHORT, 1'b0, 0);
        repeat (10) @(negedge clk50);
        chk("final_pressed_lvl", 64'(pressed), 64'd0);

        chk("events_outstanding", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
